// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MIPS-style HI/LO multiply/divide unit (shift-add multiply, restoring divide)
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             w_start,
    input  logic [5:0]       w_op_code_6,
    input  logic [WIDTH-1:0] w_input1_x,
    input  logic [WIDTH-1:0] w_input2_x,
    output logic             w_busy_1,
    output logic             w_done_1,
    output logic             w_div_zero_1,
    output logic [WIDTH-1:0] w_hi_x,
    output logic [WIDTH-1:0] w_lo_x
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [5:0] SPECIAL_MTHI  = 6'h11;
    localparam logic [5:0] SPECIAL_MTLO  = 6'h13;
    localparam logic [5:0] SPECIAL_MULT  = 6'h18;
    localparam logic [5:0] SPECIAL_MULTU = 6'h19;
    localparam logic [5:0] SPECIAL_DIV   = 6'h1a;
    localparam logic [5:0] SPECIAL_DIVU  = 6'h1b;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opb_q, opb_d, raw_q, raw_d, hi_q, hi_d, lo_q, lo_d;
    logic               div_q, div_d, neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d;
    logic               done_q, done_d, dzp_q, dzp_d;

    logic               is_mul, is_div, is_signed, a_neg, b_neg, div_ge;
    logic [WIDTH-1:0]   a_mag, b_mag, div_diff, quo, rem;
    logic [WIDTH:0]     mul_sum, div_shift;
    logic [2*WIDTH-1:0] mul_next, div_next, prod;

    assign is_mul    = w_op_code_6 == SPECIAL_MULT || w_op_code_6 == SPECIAL_MULTU;
    assign is_div    = w_op_code_6 == SPECIAL_DIV || w_op_code_6 == SPECIAL_DIVU;
    assign is_signed = w_op_code_6 == SPECIAL_MULT || w_op_code_6 == SPECIAL_DIV;
    assign a_neg     = is_signed & w_input1_x[WIDTH-1];
    assign b_neg     = is_signed & w_input2_x[WIDTH-1];
    assign a_mag     = a_neg ? -w_input1_x : w_input1_x;
    assign b_mag     = b_neg ? -w_input2_x : w_input2_x;

    // acc holds {partial product, multiplier} for multiply and {remainder, dividend/quotient} for divide
    assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, opb_q};
    assign div_diff  = div_shift[WIDTH-1:0] - opb_q;
    assign div_next  = {div_ge ? div_diff : div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], div_ge};

    assign prod = neg_q ? -acc_q : acc_q;
    assign quo  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opb_d   = opb_q;
        raw_d   = raw_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        div_d   = div_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        done_d  = 1'b0;
        dzp_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_start && (is_mul || is_div)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    div_d   = is_div;
                    neg_d   = a_neg ^ b_neg;
                    rneg_d  = a_neg;
                    dz_d    = w_input2_x == '0;
                    raw_d   = w_input1_x;
                    opb_d   = is_div ? b_mag : a_mag;
                    acc_d   = {{WIDTH{1'b0}}, is_div ? a_mag : b_mag};
                end
                hi_d = (w_start && w_op_code_6 == SPECIAL_MTHI) ? w_input1_x : hi_q;
                lo_d = (w_start && w_op_code_6 == SPECIAL_MTLO) ? w_input1_x : lo_q;
            end
            RUN: begin
                acc_d   = div_q ? div_next : mul_next;
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == CW'(WIDTH - 1)) ? FIX : RUN;
            end
            default: begin
                state_d = IDLE;
                hi_d    = div_q ? (dz_q ? raw_q : rem) : prod[2*WIDTH-1:WIDTH];
                lo_d    = div_q ? (dz_q ? {WIDTH{1'b1}} : quo) : prod[WIDTH-1:0];
                done_d  = 1'b1;
                dzp_d   = div_q & dz_q;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opb_q   <= '0;
            raw_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
            dzp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opb_q   <= opb_d;
            raw_q   <= raw_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            div_q   <= div_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            done_q  <= done_d;
            dzp_q   <= dzp_d;
        end
    end

    assign w_busy_1     = state_q != IDLE;
    assign w_done_1     = done_q;
    assign w_div_zero_1 = dzp_q;
    assign w_hi_x       = hi_q;
    assign w_lo_x       = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors, random ops against a 64-bit arithmetic model, and control corner cases
module tb_muldiv_unit;
    localparam logic [5:0] MTHI  = 6'h11;
    localparam logic [5:0] MTLO  = 6'h13;
    localparam logic [5:0] MULT  = 6'h18;
    localparam logic [5:0] MULTU = 6'h19;
    localparam logic [5:0] DIV   = 6'h1a;
    localparam logic [5:0] DIVU  = 6'h1b;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        w_start = 1'b0;
    logic [5:0]  w_op_code_6 = '0;
    logic [31:0] w_input1_x = '0;
    logic [31:0] w_input2_x = '0;
    logic        w_busy_1, w_done_1, w_div_zero_1;
    logic [31:0] w_hi_x, w_lo_x;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] a, b, hi, lo;
        logic        dz;
    } vec_t;

    vec_t vecs[12];

    muldiv_unit #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset), .w_start(w_start), .w_op_code_6(w_op_code_6),
        .w_input1_x(w_input1_x), .w_input2_x(w_input2_x), .w_busy_1(w_busy_1),
        .w_done_1(w_done_1), .w_div_zero_1(w_div_zero_1), .w_hi_x(w_hi_x), .w_lo_x(w_lo_x)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // returns {div_zero, hi, lo} from plain 64-bit arithmetic
    function automatic logic [64:0] model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint unsigned ua = 64'(a);
        longint unsigned ub = 64'(b);
        logic [63:0] p, q, r;
        if ((op == DIV || op == DIVU) && b == 0) return {1'b1, a, 32'hffffffff};
        case (op)
            MULT:    begin p = sa * sb; return {1'b0, p}; end
            MULTU:   begin p = ua * ub; return {1'b0, p}; end
            DIV:     begin q = sa / sb; r = sa % sb; return {1'b0, r[31:0], q[31:0]}; end
            default: begin q = ua / ub; r = ua % ub; return {1'b0, r[31:0], q[31:0]}; end
        endcase
    endfunction

    task automatic start_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        w_start = 1'b1;
        w_op_code_6 = op;
        w_input1_x = a;
        w_input2_x = b;
        @(posedge clock);
        #1 w_start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int busy_n);
        lat = 0;
        busy_n = 0;
        while (lat < 40) begin
            @(posedge clock);
            #1 lat++;
            if (w_done_1) break;
            if (w_busy_1) busy_n++;
        end
    endtask

    task automatic run_op(input string name, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] hi, input logic [31:0] lo, input logic dz);
        int lat, busy_n;
        start_op(op, a, b);
        wait_done(lat, busy_n);
        chk({name, "_latency"}, 64'(lat), 64'd33);
        chk({name, "_busy_cycles"}, 64'(busy_n), 64'd32);
        chk({name, "_busy_at_done"}, 64'(w_busy_1), 64'd0);
        chk({name, "_hi"}, 64'(w_hi_x), 64'(hi));
        chk({name, "_lo"}, 64'(w_lo_x), 64'(lo));
        chk({name, "_div_zero"}, 64'(w_div_zero_1), 64'(dz));
        @(posedge clock);
        #1 chk({name, "_done_pulse"}, 64'(w_done_1), 64'd0);
    endtask

    initial begin
        int lat, busy_n, dones;
        logic [31:0] prev_hi, prev_lo, ra, rb;
        logic [5:0] rop;
        logic [64:0] m;

        vecs[0]  = '{MULT,  32'hfffffffe, 32'h00000003, 32'hffffffff, 32'hfffffffa, 1'b0};
        vecs[1]  = '{MULTU, 32'hffffffff, 32'hffffffff, 32'hfffffffe, 32'h00000001, 1'b0};
        vecs[2]  = '{DIV,   32'hfffffff9, 32'h00000002, 32'hffffffff, 32'hfffffffd, 1'b0};
        vecs[3]  = '{DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0};
        vecs[4]  = '{DIV,   32'h80000000, 32'hffffffff, 32'h00000000, 32'h80000000, 1'b0};
        vecs[5]  = '{DIVU,  32'h00000005, 32'h00000000, 32'h00000005, 32'hffffffff, 1'b1};
        vecs[6]  = '{DIV,   32'hfffffff0, 32'h00000000, 32'hfffffff0, 32'hffffffff, 1'b1};
        vecs[7]  = '{MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[8]  = '{MULT,  32'h7fffffff, 32'hffffffff, 32'hffffffff, 32'h80000001, 1'b0};
        vecs[9]  = '{DIV,   32'h00000007, 32'hfffffffe, 32'h00000001, 32'hfffffffd, 1'b0};
        vecs[10] = '{MULTU, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0};
        vecs[11] = '{DIVU,  32'hffffffff, 32'h00000001, 32'h00000000, 32'hffffffff, 1'b0};

        repeat (3) @(posedge clock);
        #1;
        chk("reset_busy", 64'(w_busy_1), 64'd0);
        chk("reset_done", 64'(w_done_1), 64'd0);
        chk("reset_dz", 64'(w_div_zero_1), 64'd0);
        chk("reset_hi", 64'(w_hi_x), 64'd0);
        chk("reset_lo", 64'(w_lo_x), 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 12; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dz);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: rop = MULT;
                1: rop = MULTU;
                2: rop = DIV;
                default: rop = DIVU;
            endcase
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'h0;
                1: begin ra = 32'h80000000; rb = 32'hffffffff; end
                2: rb = rb >> $urandom_range(8, 31);
                default: ;
            endcase
            m = model(rop, ra, rb);
            run_op($sformatf("rand%0d", i), rop, ra, rb, m[63:32], m[31:0], m[64]);
        end

        // MTHI while busy is dropped; only the divide result lands in HI
        prev_hi = w_hi_x;
        start_op(DIVU, 32'd100, 32'd7);
        repeat (5) @(posedge clock);
        start_op(MTHI, 32'h12345678, 32'h0);
        chk("mthi_busy_hold", 64'(w_hi_x), 64'(prev_hi));
        wait_done(lat, busy_n);
        chk("mthi_busy_latency", 64'(lat), 64'd27);
        chk("mthi_busy_hi", 64'(w_hi_x), 64'd2);
        chk("mthi_busy_lo", 64'(w_lo_x), 64'd14);

        start_op(MTHI, 32'h12345678, 32'h0);
        chk("mthi_idle_hi", 64'(w_hi_x), 64'h12345678);
        chk("mthi_idle_lo", 64'(w_lo_x), 64'd14);
        chk("mthi_idle_busy", 64'(w_busy_1), 64'd0);
        chk("mthi_idle_done", 64'(w_done_1), 64'd0);
        start_op(MTLO, 32'hcafef00d, 32'h0);
        chk("mtlo_idle_lo", 64'(w_lo_x), 64'hcafef00d);
        chk("mtlo_idle_hi", 64'(w_hi_x), 64'h12345678);
        chk("mtlo_idle_done", 64'(w_done_1), 64'd0);

        start_op(6'h00, 32'hdeadbeef, 32'h1);
        chk("badop_busy", 64'(w_busy_1), 64'd0);
        @(posedge clock);
        #1;
        chk("badop_hi", 64'(w_hi_x), 64'h12345678);
        chk("badop_lo", 64'(w_lo_x), 64'hcafef00d);
        chk("badop_done", 64'(w_done_1), 64'd0);

        // start in the done cycle is accepted
        start_op(MULTU, 32'd6, 32'd7);
        wait_done(lat, busy_n);
        chk("b2b_first_lo", 64'(w_lo_x), 64'd42);
        w_start = 1'b1;
        w_op_code_6 = DIV;
        w_input1_x = 32'hffffff9c;
        w_input2_x = 32'd7;
        @(posedge clock);
        #1 w_start = 1'b0;
        chk("b2b_accepted_busy", 64'(w_busy_1), 64'd1);
        wait_done(lat, busy_n);
        chk("b2b_latency", 64'(lat), 64'd33);
        chk("b2b_hi", 64'(w_hi_x), 64'hfffffffe);
        chk("b2b_lo", 64'(w_lo_x), 64'hfffffff2);

        // reset at edge 10 of a divide aborts it
        start_op(DIV, 32'd1000, 32'd3);
        repeat (9) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        w_start = 1'b1;
        w_op_code_6 = MTHI;
        w_input1_x = 32'h55555555;
        @(posedge clock);
        #1;
        reset = 1'b0;
        w_start = 1'b0;
        chk("rst_mid_busy", 64'(w_busy_1), 64'd0);
        chk("rst_mid_hi", 64'(w_hi_x), 64'd0);
        chk("rst_mid_lo", 64'(w_lo_x), 64'd0);
        dones = 0;
        repeat (40) begin
            @(posedge clock);
            #1 if (w_done_1) dones++;
        end
        chk("rst_mid_no_done", 64'(dones), 64'd0);
        chk("rst_mid_hi_after", 64'(w_hi_x), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, which sets the operand and HI/LO width.
REQ-002 The module SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have port w_start, input, 1 bit: request strobe, sampled on the clock edge.
REQ-005 The module SHALL have port w_op_code_6, input, 6 bits: operation select, using the isa_codes.v macros SPECIAL_MULT, SPECIAL_MULTU, SPECIAL_DIV, SPECIAL_DIVU, SPECIAL_MTHI and SPECIAL_MTLO.
REQ-006 The module SHALL have port w_input1_x, input, WIDTH bits: multiplicand, dividend, or MTHI/MTLO source.
REQ-007 The module SHALL have port w_input2_x, input, WIDTH bits: multiplier or divisor.
REQ-008 The module SHALL have port w_busy_1, output, 1 bit: high while an iterative operation is in flight.
REQ-009 The module SHALL have port w_done_1, output, 1 bit: one-cycle pulse when HI/LO hold a new multiply/divide result.
REQ-010 The module SHALL have port w_div_zero_1, output, 1 bit: one-cycle pulse, coincident with w_done_1, flagging a zero divisor.
REQ-011 The module SHALL have port w_hi_x, output, WIDTH bits: current HI register, driven continuously for MFHI.
REQ-012 The module SHALL have port w_lo_x, output, WIDTH bits: current LO register, driven continuously for MFLO.

Function
REQ-013 The module SHALL implement three states: IDLE, RUN and FIX.
REQ-014 In IDLE, w_start=1 with a mult/div opcode SHALL, at that edge, latch operand magnitudes (signed ops) or raw values (unsigned ops), latch the sign flags, clear the iteration counter, set w_busy_1, and enter RUN.
REQ-015 RUN SHALL last exactly WIDTH cycles: one shift-add multiply step, or one restoring-divide step, per cycle; the counter counts 0..WIDTH-1, then the state goes to FIX.
REQ-016 FIX SHALL last one cycle and apply the signs; at the end of FIX, HI/LO are written, w_busy_1 clears, w_done_1 goes high for one cycle, and the state returns to IDLE.
REQ-017 Latency from the accepting edge to the first cycle with w_done_1=1 and updated HI/LO SHALL be WIDTH+1 edges (33 for WIDTH=32); w_busy_1=0 during the w_done_1 cycle.
REQ-018 Multiply SHALL write the 2*WIDTH product as HI=upper, LO=lower; the signed product is negated when the operand signs differ.
REQ-019 Divide SHALL write LO=quotient and HI=remainder; the quotient is negative iff the operand signs differ; the remainder takes the dividend's sign.
REQ-020 Signed overflow (most-negative / -1) SHALL give LO=most-negative, HI=0, with no flag.
REQ-021 A zero divisor (DIV or DIVU) SHALL still take WIDTH+1 cycles, then write HI=raw w_input1_x and LO=all ones, and pulse w_div_zero_1 with w_done_1.
REQ-022 MTHI/MTLO with w_start in IDLE SHALL write w_input1_x to HI/LO at that edge; w_busy_1 and w_done_1 are not asserted.
REQ-023 w_start while w_busy_1=1 SHALL be ignored entirely (no queueing, no HI/LO change), including MTHI/MTLO.
REQ-024 w_start with any other opcode SHALL be ignored.
REQ-025 w_start in the same cycle as w_done_1 SHALL be accepted, since the state is IDLE.
REQ-026 HI/LO SHALL change only at the FIX writeback, on MTHI/MTLO, or on reset.

Reset
REQ-027 reset=1 at a clock edge SHALL force state IDLE, counter 0, HI=0, LO=0, and w_busy_1, w_done_1 and w_div_zero_1 to 0; reset takes priority over w_start.
REQ-028 Reset mid-operation SHALL abort the operation with no writeback and no w_done_1 pulse.

Verification
REQ-029 MULT 0xFFFFFFFE x 0x00000003 -> at edge 33: HI=0xFFFFFFFF, LO=0xFFFFFFFA, w_done_1=1 for one cycle; w_busy_1=1 during edges 1..32.
REQ-030 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-031 DIV 0xFFFFFFF9 / 0x00000002 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/2 -> LO=3, HI=1.
REQ-032 DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0, w_div_zero_1=0; DIVU 5/0 -> HI=5, LO=0xFFFFFFFF, w_div_zero_1=1 with w_done_1.
REQ-033 MTHI 0x12345678 issued during DIV busy -> ignored, HI reflects only the DIV result; MTHI issued when idle -> HI=0x12345678 next cycle, no w_done_1.
REQ-034 Reset asserted at edge 10 of a DIV -> w_busy_1=0, HI=LO=0, and no w_done_1 pulse in the following 40 cycles.
